ipv4_local_lut_mgr: RTL and testbench
=====================================

Name: ipv4_local_lut_mgr

Overview:
- Command sequencer that owns the rd/wr request port of the IPv4 local-address LUT, in the Bus2IP_Clk domain.
- Converts software commands (ADD address, DELETE address, CLEAR table) into row-by-row read scans and single-row writes.
- Software no longer tracks row indices.
- Maintains a live entry count. Value 0.0.0.0 marks an empty row.

Parameters:
- IPV4_LOCAL_LUT_ROWS, 3, number of LUT rows managed.
- IPV4_LOCAL_LUT_ROW_BITS, 5, row address width; 2^ROW_BITS >= ROWS.
- ACK_TIMEOUT, 16, cycles to wait for a LUT ack before aborting.

Ports:
- Bus2IP_Clk  in  1  clock.
- reset  in  1  reset.
- i_cmd_valid  in  1  command strobe.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_op  in  2  00 ADD, 01 DEL, 10 CLEAR, 11 reserved.
- i_cmd_ipv4_addr  in  32  operand address.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_status  out  2  00 OK, 01 EXISTS (ADD) / NOT_FOUND (DEL), 10 FULL, 11 ERROR.
- o_rsp_row  out  ROW_BITS  affected or matching row.
- o_entry_count  out  ROW_BITS+1  occupied rows.
- o_lut_rd_req  out  1  LUT read request.
- i_lut_rd_ack  in  1  LUT read ack.
- o_lut_rd_addr  out  ROW_BITS  LUT read row.
- i_lut_rd_ipv4_addr  in  32  LUT read data, valid in the cycle i_lut_rd_ack is high.
- o_lut_wr_req  out  1  LUT write request.
- i_lut_wr_ack  in  1  LUT write ack.
- o_lut_wr_addr  out  ROW_BITS  LUT write row.
- o_lut_wr_ipv4_addr  out  32  LUT write data.

Behaviour:
- Clock and reset: clock Bus2IP_Clk; reset is synchronous, active-high.
- Reset values:
  - state IDLE, so o_cmd_ready=1.
  - All other outputs 0; o_entry_count=0, matching the LUT's own reset-to-zero.
- Reset mid-operation: return to IDLE on the next edge and drop the command. No response is issued and the count is not changed.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- Accept: command accepted when i_cmd_valid and o_cmd_ready are both high, at cycle T. Op and address are latched, and the row counter is cleared.
- Immediate ERROR (RESP at T+1, no LUT access):
  - op 11.
  - ADD or DEL of 0.0.0.0.
- RD_REQ: o_lut_rd_req=1 for exactly one cycle, rd_addr = row counter. Next state RD_WAIT.
- RD_WAIT: wait for i_lut_rd_ack and sample i_lut_rd_ipv4_addr in the ack cycle.
  - ADD: record the first row reading 0 as the free row; record a match as the matching row.
  - ADD always scans all rows, for deterministic latency.
  - DEL: stop at the first match and go to WR_REQ with data 0.
  - Row counter increments and stops at ROWS-1; it never wraps.
- End of ADD scan: match → RESP EXISTS, row = match, no write. Else free row → WR_REQ. Else RESP FULL.
- End of DEL scan without a match: RESP NOT_FOUND, row 0.
- CLEAR: WR_REQ/WR_WAIT for rows 0..ROWS-1 with data 0, then RESP OK, row 0, count set to 0.
- WR_REQ: o_lut_wr_req=1 for one cycle with address and data stable until the ack. Next state WR_WAIT.
- Request exclusivity: rd_req and wr_req are never high in the same cycle.
- Timeout: each WAIT state counts cycles. If no ack arrives within ACK_TIMEOUT cycles → RESP ERROR, row = current row, count unchanged.
- Stale acks: acks arriving outside the matching WAIT state are ignored.
- RESP: o_rsp_valid=1 for one cycle, status and row held until the next response. Next state IDLE.
- Count update: ADD OK +1, DEL OK −1, applied in the RESP cycle.
- Latency with the standard LUT (ack one cycle after req):
  - ADD OK: rsp at T+2·ROWS+3.
  - ADD EXISTS/FULL: rsp at T+2·ROWS+1.
  - DEL at row r: rsp at T+2(r+1)+3.

Test Plan:
1. Reset, ROWS=3, real LUT attached → o_cmd_ready=1, o_entry_count=0, both reqs 0.
2. ADD 0x0A000001 at T → rsp at T+9, OK, row 0, count 1. Then ADD 0x0A000002 → OK, row 1, count 2.
3. ADD 0x0A000001 again → EXISTS, row 0, rsp at T+7, no wr_req seen, count 2. ADD 0x00000000 → ERROR at T+1.
4. Fill to 3 rows, then ADD 0x0A000004 → FULL at T+7, count 3, LUT unchanged.
5. DEL 0x0A000002 → wr_addr 1, wr data 0, OK, row 1, count 2. DEL it again → NOT_FOUND. CLEAR → three writes of 0, count 0.
6. LUT model withholds rd_ack → ERROR exactly ACK_TIMEOUT cycles after RD_WAIT entry. Separately, assert reset mid-scan → IDLE next cycle, no rsp_valid, late ack ignored.

Source files
------------

// File: rtl/ipv4_local_lut_mgr_if.sv
// Bundles the software command/response port and the LUT request port of the
// IPv4 local-address LUT manager. The manager owns the LUT request side, so it
// uses the master modport; software plus the LUT itself sit on the slave side.
interface ipv4_local_lut_mgr_if #(
  parameter int ROW_BITS = 5
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [1:0]          i_cmd_op;
  logic [31:0]         i_cmd_ipv4_addr;
  logic                o_rsp_valid;
  logic [1:0]          o_rsp_status;
  logic [ROW_BITS-1:0] o_rsp_row;
  logic [ROW_BITS:0]   o_entry_count;
  logic                o_lut_rd_req;
  logic                i_lut_rd_ack;
  logic [ROW_BITS-1:0] o_lut_rd_addr;
  logic [31:0]         i_lut_rd_ipv4_addr;
  logic                o_lut_wr_req;
  logic                i_lut_wr_ack;
  logic [ROW_BITS-1:0] o_lut_wr_addr;
  logic [31:0]         o_lut_wr_ipv4_addr;

  modport master (
    input  i_cmd_valid, i_cmd_op, i_cmd_ipv4_addr,
    output o_cmd_ready, o_rsp_valid, o_rsp_status, o_rsp_row, o_entry_count,
    output o_lut_rd_req, o_lut_rd_addr, o_lut_wr_req, o_lut_wr_addr, o_lut_wr_ipv4_addr,
    input  i_lut_rd_ack, i_lut_rd_ipv4_addr, i_lut_wr_ack
  );

  modport slave (
    output i_cmd_valid, i_cmd_op, i_cmd_ipv4_addr,
    input  o_cmd_ready, o_rsp_valid, o_rsp_status, o_rsp_row, o_entry_count,
    input  o_lut_rd_req, o_lut_rd_addr, o_lut_wr_req, o_lut_wr_addr, o_lut_wr_ipv4_addr,
    output i_lut_rd_ack, i_lut_rd_ipv4_addr, i_lut_wr_ack
  );
endinterface

// File: rtl/ipv4_local_lut_mgr.sv
// IPv4 local-address LUT manager: turns ADD / DEL / CLEAR commands into row
// scans and single-row writes, and keeps a live count of occupied rows.
// A row holding 0.0.0.0 is treated as empty.
module ipv4_local_lut_mgr #(
  parameter int IPV4_LOCAL_LUT_ROWS     = 3,
  parameter int IPV4_LOCAL_LUT_ROW_BITS = 5,
  parameter int ACK_TIMEOUT             = 16
) (
  input  logic Bus2IP_Clk,
  input  logic reset,
  ipv4_local_lut_mgr_if.master bus
);

  localparam int RB     = IPV4_LOCAL_LUT_ROW_BITS;
  localparam int WAIT_W = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [RB-1:0]     LAST_ROW  = RB'(IPV4_LOCAL_LUT_ROWS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_DEL   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_EXIST = 2'b01;  // EXISTS for ADD, NOT_FOUND for DEL
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         op_reg, op_next;
  logic [31:0]        addr_reg, addr_next;
  logic [RB-1:0]      row_reg, row_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic               free_found_reg, free_found_next;
  logic [RB-1:0]      free_row_reg, free_row_next;
  logic               match_found_reg, match_found_next;
  logic [RB-1:0]      match_row_reg, match_row_next;
  logic [RB-1:0]      wr_addr_reg, wr_addr_next;
  logic [31:0]        wr_data_reg, wr_data_next;
  logic [1:0]         rsp_status_reg, rsp_status_next;
  logic [RB-1:0]      rsp_row_reg, rsp_row_next;
  logic [RB:0]        count_reg, count_next;

  // Scan bookkeeping including the row being read in this ack cycle, so the
  // end-of-scan decision can use the last row without an extra cycle.
  logic          last_row;
  logic          rd_zero, rd_match;
  logic          free_found_now, match_found_now;
  logic [RB-1:0] free_row_now, match_row_now;

  assign last_row        = (row_reg == LAST_ROW);
  assign rd_zero         = (bus.i_lut_rd_ipv4_addr == 32'd0);
  assign rd_match        = (bus.i_lut_rd_ipv4_addr == addr_reg);
  assign free_found_now  = free_found_reg | rd_zero;
  assign free_row_now    = free_found_reg ? free_row_reg : row_reg;
  assign match_found_now = match_found_reg | rd_match;
  assign match_row_now   = match_found_reg ? match_row_reg : row_reg;

  assign bus.o_cmd_ready        = (state_reg == S_IDLE);
  assign bus.o_lut_rd_req       = (state_reg == S_RD_REQ);
  assign bus.o_lut_wr_req       = (state_reg == S_WR_REQ);
  assign bus.o_rsp_valid        = (state_reg == S_RESP);
  assign bus.o_lut_rd_addr      = row_reg;
  assign bus.o_lut_wr_addr      = wr_addr_reg;
  assign bus.o_lut_wr_ipv4_addr = wr_data_reg;
  assign bus.o_rsp_status       = rsp_status_reg;
  assign bus.o_rsp_row          = rsp_row_reg;
  assign bus.o_entry_count      = count_reg;

  // State and datapath registers; reset drops any command in flight.
  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      op_reg          <= '0;
      addr_reg        <= '0;
      row_reg         <= '0;
      wait_reg        <= '0;
      free_found_reg  <= 1'b0;
      free_row_reg    <= '0;
      match_found_reg <= 1'b0;
      match_row_reg   <= '0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      rsp_status_reg  <= '0;
      rsp_row_reg     <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      addr_reg        <= addr_next;
      row_reg         <= row_next;
      wait_reg        <= wait_next;
      free_found_reg  <= free_found_next;
      free_row_reg    <= free_row_next;
      match_found_reg <= match_found_next;
      match_row_reg   <= match_row_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      rsp_status_reg  <= rsp_status_next;
      rsp_row_reg     <= rsp_row_next;
      count_reg       <= count_next;
    end
  end

  // Next-state logic; response fields and the count are loaded on entry to RESP.
  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    addr_next        = addr_reg;
    row_next         = row_reg;
    wait_next        = wait_reg;
    free_found_next  = free_found_reg;
    free_row_next    = free_row_reg;
    match_found_next = match_found_reg;
    match_row_next   = match_row_reg;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    rsp_status_next  = rsp_status_reg;
    rsp_row_next     = rsp_row_reg;
    count_next       = count_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          op_next          = bus.i_cmd_op;
          addr_next        = bus.i_cmd_ipv4_addr;
          row_next         = '0;
          free_found_next  = 1'b0;
          match_found_next = 1'b0;
          if (bus.i_cmd_op == OP_RSVD ||
              (bus.i_cmd_op != OP_CLEAR && bus.i_cmd_ipv4_addr == 32'd0)) begin
            rsp_status_next = ST_ERROR;
            rsp_row_next    = '0;
            state_next      = S_RESP;
          end else if (bus.i_cmd_op == OP_CLEAR) begin
            wr_addr_next = '0;
            wr_data_next = 32'd0;
            state_next   = S_WR_REQ;
          end else begin
            state_next = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        wait_next  = '0;
        state_next = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (bus.i_lut_rd_ack) begin
          if (op_reg == OP_ADD) begin
            free_found_next  = free_found_now;
            free_row_next    = free_row_now;
            match_found_next = match_found_now;
            match_row_next   = match_row_now;
            if (!last_row) begin
              row_next   = row_reg + 1'b1;
              state_next = S_RD_REQ;
            end else if (match_found_now) begin
              rsp_status_next = ST_EXIST;
              rsp_row_next    = match_row_now;
              state_next      = S_RESP;
            end else if (free_found_now) begin
              wr_addr_next = free_row_now;
              wr_data_next = addr_reg;
              state_next   = S_WR_REQ;
            end else begin
              rsp_status_next = ST_FULL;
              rsp_row_next    = '0;
              state_next      = S_RESP;
            end
          end else begin
            if (rd_match) begin
              wr_addr_next = row_reg;
              wr_data_next = 32'd0;
              state_next   = S_WR_REQ;
            end else if (!last_row) begin
              row_next   = row_reg + 1'b1;
              state_next = S_RD_REQ;
            end else begin
              rsp_status_next = ST_EXIST;
              rsp_row_next    = '0;
              state_next      = S_RESP;
            end
          end
        end else if (wait_reg == WAIT_LAST) begin
          rsp_status_next = ST_ERROR;
          rsp_row_next    = row_reg;
          state_next      = S_RESP;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end

      S_WR_REQ: begin
        wait_next  = '0;
        state_next = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        if (bus.i_lut_wr_ack) begin
          if (op_reg == OP_CLEAR) begin
            if (last_row) begin
              rsp_status_next = ST_OK;
              rsp_row_next    = '0;
              count_next      = '0;
              state_next      = S_RESP;
            end else begin
              row_next     = row_reg + 1'b1;
              wr_addr_next = row_reg + 1'b1;
              state_next   = S_WR_REQ;
            end
          end else if (op_reg == OP_ADD) begin
            rsp_status_next = ST_OK;
            rsp_row_next    = wr_addr_reg;
            count_next      = count_reg + 1'b1;
            state_next      = S_RESP;
          end else if (op_reg == OP_DEL) begin
            rsp_status_next = ST_OK;
            rsp_row_next    = wr_addr_reg;
            count_next      = count_reg - 1'b1;
            state_next      = S_RESP;
          end else begin
            rsp_status_next = ST_ERROR;
            rsp_row_next    = wr_addr_reg;
            state_next      = S_RESP;
          end
        end else if (wait_reg == WAIT_LAST) begin
          rsp_status_next = ST_ERROR;
          rsp_row_next    = wr_addr_reg;
          state_next      = S_RESP;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end

      S_RESP: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ipv4_local_lut_mgr.sv
// Scoreboard bench for ipv4_local_lut_mgr with a small LUT model that acks one
// cycle after each request. Expected responses come from a reference table.
module tb_ipv4_local_lut_mgr;

  localparam int ROWS = 3;
  localparam int RB   = 5;
  localparam int TO   = 16;

  localparam logic [1:0] OP_ADD = 2'b00, OP_DEL = 2'b01, OP_CLR = 2'b10, OP_RSV = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_EXIST = 2'b01, ST_FULL = 2'b10, ST_ERR = 2'b11;

  logic Bus2IP_Clk = 1'b0;
  logic reset      = 1'b1;
  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  ipv4_local_lut_mgr_if #(.ROW_BITS(RB)) bus ();

  ipv4_local_lut_mgr #(
    .IPV4_LOCAL_LUT_ROWS(ROWS),
    .IPV4_LOCAL_LUT_ROW_BITS(RB),
    .ACK_TIMEOUT(TO)
  ) dut (
    .Bus2IP_Clk(Bus2IP_Clk),
    .reset(reset),
    .bus(bus.master)
  );

  typedef struct {
    logic [1:0]    status;
    logic [RB-1:0] row;
    logic [RB:0]   count;
    int            cycle;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] lut_mem [ROWS];
  logic [31:0] ref_mem [ROWS];
  int          ref_count = 0;
  logic        hold_rd   = 1'b0;
  logic        inject_rd = 1'b0;
  int          wr_pulses = 0;
  logic [RB-1:0] last_wr_addr = '0;
  logic [31:0]   last_wr_data = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge Bus2IP_Clk) cyc <= cyc + 1;

  // LUT model: one-cycle ack, reset-to-zero contents, optional withheld/forced read ack.
  always @(posedge Bus2IP_Clk) begin
    if (bus.o_lut_wr_req) wr_pulses <= wr_pulses + 1;
    if (reset) begin
      bus.i_lut_rd_ack       <= 1'b0;
      bus.i_lut_wr_ack       <= 1'b0;
      bus.i_lut_rd_ipv4_addr <= '0;
      for (int i = 0; i < ROWS; i++) lut_mem[i] <= '0;
    end else begin
      bus.i_lut_rd_ack       <= (bus.o_lut_rd_req && !hold_rd) || inject_rd;
      bus.i_lut_rd_ipv4_addr <= (int'(bus.o_lut_rd_addr) < ROWS) ? lut_mem[bus.o_lut_rd_addr] : 32'd0;
      bus.i_lut_wr_ack       <= bus.o_lut_wr_req;
      if (bus.o_lut_wr_req) begin
        last_wr_addr <= bus.o_lut_wr_addr;
        last_wr_data <= bus.o_lut_wr_ipv4_addr;
        if (int'(bus.o_lut_wr_addr) < ROWS) lut_mem[bus.o_lut_wr_addr] <= bus.o_lut_wr_ipv4_addr;
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge Bus2IP_Clk) begin
    if (!reset) begin
      check_val("req_exclusive", 64'(bus.o_lut_rd_req & bus.o_lut_wr_req), 64'd0);
      if (bus.o_rsp_valid) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_rsp", 64'(bus.o_rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("rsp_status", 64'(bus.o_rsp_status), 64'(e.status));
          check_val("rsp_row", 64'(bus.o_rsp_row), 64'(e.row));
          check_val("rsp_count", 64'(bus.o_entry_count), 64'(e.count));
          check_val("rsp_cycle", 64'(cyc), 64'(e.cycle));
          $display("rsp status=%0d row=%0d count=%0d at cycle %0d", bus.o_rsp_status,
                   bus.o_rsp_row, bus.o_entry_count, cyc);
        end
      end
    end
  end

  // Reference behaviour: expected status, row, count and latency of one command.
  task automatic predict(input logic [1:0] op, input logic [31:0] a, input bit rd_timeout,
                         output exp_t e);
    int hit, free_r, lat;
    hit = -1; free_r = -1; lat = 1;
    e.status = ST_OK;
    e.row    = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (ref_mem[i] == a) hit = i;
      if (ref_mem[i] == 32'd0) free_r = i;
    end
    if (op == OP_RSV || (op != OP_CLR && a == 32'd0)) begin
      e.status = ST_ERR;
    end else if (rd_timeout) begin
      e.status = ST_ERR;
      lat = 2 + TO;
    end else if (op == OP_ADD) begin
      lat = 2 * ROWS + 1;
      if (hit >= 0) begin
        e.status = ST_EXIST; e.row = RB'(hit);
      end else if (free_r >= 0) begin
        e.row = RB'(free_r); ref_mem[free_r] = a; ref_count++; lat = 2 * ROWS + 3;
      end else begin
        e.status = ST_FULL;
      end
    end else if (op == OP_DEL) begin
      if (hit >= 0) begin
        e.row = RB'(hit); ref_mem[hit] = 32'd0; ref_count--; lat = 2 * (hit + 1) + 3;
      end else begin
        e.status = ST_EXIST; lat = 2 * ROWS + 1;
      end
    end else begin
      for (int i = 0; i < ROWS; i++) ref_mem[i] = 32'd0;
      ref_count = 0;
      lat = 2 * ROWS + 1;
    end
    e.count = (RB + 1)'(ref_count);
    e.cycle = cyc + lat;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !bus.o_cmd_ready; i++) @(negedge Bus2IP_Clk);
    if (!bus.o_cmd_ready) check_val("ready_timeout", 64'(bus.o_cmd_ready), 64'd1);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input bit rd_timeout);
    exp_t e;
    @(negedge Bus2IP_Clk);
    wait_ready();
    predict(op, a, rd_timeout, e);
    sb_q.push_back(e);
    $display("cmd op=%0d addr=%08h exp_status=%0d exp_row=%0d", op, a, e.status, e.row);
    bus.i_cmd_valid     = 1'b1;
    bus.i_cmd_op        = op;
    bus.i_cmd_ipv4_addr = a;
    @(negedge Bus2IP_Clk);
    bus.i_cmd_valid = 1'b0;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge Bus2IP_Clk);
    if (sb_q.size() != 0) begin
      check_val("rsp_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_lut(input string tag);
    for (int i = 0; i < ROWS; i++) check_val(tag, 64'(lut_mem[i]), 64'(ref_mem[i]));
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < ROWS; i++) ref_mem[i] = 32'd0;
    bus.i_cmd_valid     = 1'b0;
    bus.i_cmd_op        = 2'b00;
    bus.i_cmd_ipv4_addr = 32'd0;
    repeat (3) @(negedge Bus2IP_Clk);
    check_val("rst_ready", 64'(bus.o_cmd_ready), 64'd1);
    check_val("rst_count", 64'(bus.o_entry_count), 64'd0);
    check_val("rst_rd_req", 64'(bus.o_lut_rd_req), 64'd0);
    check_val("rst_wr_req", 64'(bus.o_lut_wr_req), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    reset = 1'b0;

    send(OP_ADD, 32'h0A000001, 1'b0);
    send(OP_ADD, 32'h0A000002, 1'b0);
    wr_before = wr_pulses;
    send(OP_ADD, 32'h0A000001, 1'b0);
    check_val("exists_no_write", 64'(wr_pulses - wr_before), 64'd0);
    send(OP_ADD, 32'h00000000, 1'b0);
    send(OP_ADD, 32'h0A000003, 1'b0);
    send(OP_ADD, 32'h0A000004, 1'b0);
    check_lut("full_lut");
    send(OP_DEL, 32'h0A000002, 1'b0);
    check_val("del_wr_addr", 64'(last_wr_addr), 64'd1);
    check_val("del_wr_data", 64'(last_wr_data), 64'd0);
    send(OP_DEL, 32'h0A000002, 1'b0);
    send(OP_DEL, 32'h00000000, 1'b0);
    send(OP_RSV, 32'h0A000007, 1'b0);
    send(OP_ADD, 32'h0A000005, 1'b0);
    check_lut("refill_lut");
    wr_before = wr_pulses;
    send(OP_CLR, 32'h0, 1'b0);
    check_val("clear_writes", 64'(wr_pulses - wr_before), 64'(ROWS));
    check_lut("clear_lut");

    // Read ack withheld: ERROR after the timeout, count unchanged.
    send(OP_ADD, 32'h0A000001, 1'b0);
    hold_rd = 1'b1;
    send(OP_ADD, 32'h0A000009, 1'b1);
    hold_rd = 1'b0;

    // Reset in the middle of a scan, then a stray read ack while idle.
    @(negedge Bus2IP_Clk);
    wait_ready();
    hold_rd             = 1'b1;
    bus.i_cmd_valid     = 1'b1;
    bus.i_cmd_op        = OP_ADD;
    bus.i_cmd_ipv4_addr = 32'h0A00000B;
    @(negedge Bus2IP_Clk);
    bus.i_cmd_valid = 1'b0;
    repeat (2) @(negedge Bus2IP_Clk);
    check_val("midscan_busy", 64'(bus.o_cmd_ready), 64'd0);
    reset = 1'b1;
    @(negedge Bus2IP_Clk);
    check_val("midrst_ready", 64'(bus.o_cmd_ready), 64'd1);
    check_val("midrst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    check_val("midrst_count", 64'(bus.o_entry_count), 64'd0);
    reset   = 1'b0;
    hold_rd = 1'b0;
    for (int i = 0; i < ROWS; i++) ref_mem[i] = 32'd0;
    ref_count = 0;
    inject_rd = 1'b1;
    @(negedge Bus2IP_Clk);
    inject_rd = 1'b0;
    repeat (4) @(negedge Bus2IP_Clk);
    check_val("stale_ack_ready", 64'(bus.o_cmd_ready), 64'd1);
    check_val("stale_ack_count", 64'(bus.o_entry_count), 64'd0);
    send(OP_ADD, 32'h0A000006, 1'b0);

    repeat (3) @(negedge Bus2IP_Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
